// File: rtl/ds_arb_pkg.sv
// ds_arb_pkg: shared FSM type and round-robin pick helper for ds_rr_arbiter
package ds_arb_pkg;
  typedef enum logic {ST_IDLE, ST_GRANT} ds_arb_state_t;
  localparam int MAX_IN = 32;
  localparam int PICK_W = $clog2(MAX_IN);
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_IN-1:0] req,
    input logic [PICK_W-1:0] last,
    input logic [PICK_W:0]   n
  );
    logic [PICK_W:0] idx;
    logic [PICK_W:0] kv;
    logic            found;
    rr_pick = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_IN; k++) begin
      kv = (PICK_W+1)'(k);
      idx = {1'b0, last} + kv;
      idx = idx >= n ? idx - n : idx;
      if (!found && kv <= n && req[idx[PICK_W-1:0]]) begin
        rr_pick = idx[PICK_W-1:0];
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/ds_mux.sv
// ds_mux: steer one of N streams onto a shared output and route ready back to the selected input
module ds_mux #(
  parameter int WIDTH = 9,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic                  en,
  input  logic [SW-1:0]         sel,
  input  logic [N-1:0][WIDTH-1:0] i_dat,
  input  logic [N-1:0]          i_val,
  output logic [N-1:0]          i_rdy,
  output logic [WIDTH-1:0]      o_dat,
  output logic                  o_val,
  input  logic                  o_rdy
);
  always_comb begin
    o_dat = i_dat[sel];
    o_val = en & i_val[sel];
    i_rdy = en ? N'(o_rdy) << sel : '0;
  end
endmodule

// File: rtl/ds_rr_arbiter.sv
// ds_rr_arbiter: round-robin packet arbiter sharing one stream output among INPUTS producers
module ds_rr_arbiter
  import ds_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int INPUTS = 4,
  parameter int BURST = 0,
  localparam int SW = $clog2(INPUTS)
) (
  input  logic                        reset,
  input  logic                        clk,
  input  logic [INPUTS-1:0][WIDTH-1:0] i_dat,
  input  logic [INPUTS-1:0]           i_eop,
  input  logic [INPUTS-1:0]           i_val,
  output logic [INPUTS-1:0]           i_rdy,
  output logic [WIDTH-1:0]            o_dat,
  output logic                        o_eop,
  output logic                        o_val,
  input  logic                        o_rdy,
  output logic [SW-1:0]               o_sel
);
  localparam int CW = BURST > 0 ? $clog2(BURST + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST > 0 ? BURST - 1 : 0);
  ds_arb_state_t state_q, state_d;
  logic [SW-1:0] grant_q, grant_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INPUTS-1:0][WIDTH:0] mux_in;
  logic [WIDTH:0] mux_out;
  logic in_grant, beat, rel;
  always_comb begin
    for (int i = 0; i < INPUTS; i++) mux_in[i] = {i_eop[i], i_dat[i]};
  end
  assign in_grant = state_q == ST_GRANT;
  ds_mux #(.WIDTH(WIDTH + 1), .N(INPUTS)) u_mux (
    .en(in_grant),
    .sel(grant_q),
    .i_dat(mux_in),
    .i_val(i_val),
    .i_rdy(i_rdy),
    .o_dat(mux_out),
    .o_val(o_val),
    .o_rdy(o_rdy)
  );
  assign o_dat = mux_out[WIDTH-1:0];
  assign o_eop = in_grant & mux_out[WIDTH];
  assign o_sel = grant_q;
  assign beat = o_val & o_rdy;
  assign rel = beat & (mux_out[WIDTH] | (BURST > 0 && cnt_q == CNT_LAST));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (!in_grant) begin
      if (|i_val) begin
        state_d = ST_GRANT;
        grant_d = SW'(rr_pick(MAX_IN'(i_val), PICK_W'(last_q), (PICK_W+1)'(INPUTS)));
      end
    end else if (rel) begin
      state_d = ST_IDLE;
      last_d = grant_q;
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q <= SW'(INPUTS - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
